// File: rtl/clock_stepper.sv
// Run/step clock-enable generator: one-cycle clk_en strobes from a RUN divider or a debounced STEP button.
// Define AUTO_REPEAT_EN to auto-repeat step strobes while the step button is held.
//
// state    | meaning
// S_STEP   | one strobe per debounced step press; divider held at 0
// S_RUN    | strobe every RUN_DIV cycles from the free-running divider
// S_HALTED | CPU reported halt; strobes suppressed until reset
module clock_stepper #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned RUN_DIV         = 1200000,
    parameter int unsigned REPEAT_DELAY    = 10000000,
    parameter int unsigned REPEAT_PERIOD   = 2000000
) (
    input  logic clk,
    input  logic reset,
    input  logic step_btn,
    input  logic mode_btn,
    input  logic halt_i,
    output logic clk_en,
    output logic run_mode_o,
    output logic halted_o,
    output logic heartbeat_o
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned DIV_W = $clog2(RUN_DIV);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    if (DEBOUNCE_CYCLES < 1 || RUN_DIV < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("clock_stepper: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_STEP   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    // bit 0 = step button, bit 1 = mode button
    logic [1:0]      sync_a, sync_b, lvl, lvl_q, rise;
    logic [DB_W-1:0] db_cnt [2];
    logic            step_rise, mode_rise;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic             strobe_q, strobe_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a    <= '0;
            sync_b    <= '0;
            lvl       <= '0;
            lvl_q     <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            sync_a <= {mode_btn, step_btn};
            sync_b <= sync_a;
            lvl_q  <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    lvl[i]    <= ~lvl[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign rise      = lvl & ~lvl_q;
    assign step_rise = rise[0];
    assign mode_rise = rise[1];

`ifdef AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt, rep_target;
    logic             rep_act, rep_act_nxt, rep_first, rep_first_nxt;

    // First repeat waits the long delay, later ones use the shorter period
    assign rep_target = rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_act   <= 1'b0;
            rep_first <= 1'b0;
        end else begin
            rep_cnt   <= rep_cnt_nxt;
            rep_act   <= rep_act_nxt;
            rep_first <= rep_first_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        div_nxt    = '0;
        strobe_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
        rep_cnt_nxt   = '0;
        rep_act_nxt   = 1'b0;
        rep_first_nxt = 1'b0;
`endif
        if (halt_i) begin
            state_nxt = S_HALTED;
        end else begin
            case (state)
                S_STEP: begin
                    strobe_nxt = step_rise;
`ifdef AUTO_REPEAT_EN
                    if (step_rise) begin
                        rep_act_nxt   = 1'b1;
                        rep_first_nxt = 1'b1;
                    end else if (rep_act && lvl[0]) begin
                        rep_act_nxt   = 1'b1;
                        rep_first_nxt = rep_first;
                        if (rep_cnt == rep_target) begin
                            strobe_nxt    = 1'b1;
                            rep_first_nxt = 1'b0;
                        end else begin
                            rep_cnt_nxt = rep_cnt + REP_W'(1);
                        end
                    end
`endif
                    if (mode_rise) begin
                        state_nxt = S_RUN;
`ifdef AUTO_REPEAT_EN
                        rep_act_nxt = 1'b0;
                        rep_cnt_nxt = '0;
`endif
                    end
                end
                S_RUN: begin
                    // a strobe due on the exit cycle is still issued
                    if (div_cnt == DIV_LAST) begin
                        strobe_nxt = 1'b1;
                    end else begin
                        div_nxt = div_cnt + DIV_W'(1);
                    end
                    if (mode_rise) begin
                        state_nxt = S_STEP;
                        div_nxt   = '0;
                    end
                end
                S_HALTED: begin
                    state_nxt = S_HALTED;
                end
                default: begin
                    state_nxt = S_STEP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_STEP;
            div_cnt     <= '0;
            strobe_q    <= 1'b0;
            heartbeat_o <= 1'b0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= div_nxt;
            strobe_q    <= strobe_nxt;
            heartbeat_o <= heartbeat_o ^ clk_en;
        end
    end

    // halt masks the registered strobe in the very cycle it is raised
    assign clk_en     = strobe_q & ~halt_i;
    assign run_mode_o = (state == S_RUN);
    assign halted_o   = (state == S_HALTED);

endmodule

// File: tb/tb_clock_stepper.sv
// Self-checking bench for clock_stepper: directed scenarios plus randomized buttons against a cycle-level reference model.
module tb_clock_stepper;

    localparam int P_DB  = 4;
    localparam int P_DIV = 5;
    localparam int P_RD  = 20;
    localparam int P_RP  = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic step_btn = 1'b0;
    logic mode_btn = 1'b0;
    logic halt_i   = 1'b0;
    logic clk_en, run_mode_o, halted_o, heartbeat_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    clock_stepper #(
        .DEBOUNCE_CYCLES(P_DB),
        .RUN_DIV        (P_DIV),
        .REPEAT_DELAY   (P_RD),
        .REPEAT_PERIOD  (P_RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step_btn   (step_btn),
        .mode_btn   (mode_btn),
        .halt_i     (halt_i),
        .clk_en     (clk_en),
        .run_mode_o (run_mode_o),
        .halted_o   (halted_o),
        .heartbeat_o(heartbeat_o)
    );

    // Reference model. Buttons are seen two edges late, a level is accepted after
    // P_DB consecutive disagreeing samples, a rising level acts on the next edge.
    // m_mode: 0 = step, 1 = run, 2 = halted. m_n counts cycles since RUN entry.
    logic [1:0] m_h0, m_h1, m_lvl, m_pend;
    int         m_run [2];
    int         m_mode, m_n, m_t;
    bit         m_rep_on, m_strobe, m_hb, m_ns;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_h0 = '0; m_h1 = '0; m_lvl = '0; m_pend = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_mode = 0; m_n = 0; m_t = 0;
            m_rep_on = 0; m_strobe = 0; m_hb = 0;
        end else begin
            m_hb = m_hb ^ (m_strobe & ~halt_i);
            m_ns = 0;
            if (halt_i) begin
                m_mode = 2;
                m_rep_on = 0;
            end else if (m_mode == 0) begin
                if (m_pend[0]) begin
                    m_ns = 1; m_rep_on = 1; m_t = 0;
                end else if (REP_ON && m_rep_on && m_lvl[0]) begin
                    m_t++;
                    if (m_t == P_RD || (m_t > P_RD && (m_t - P_RD) % P_RP == 0)) m_ns = 1;
                end else begin
                    m_rep_on = 0;
                end
                if (m_pend[1]) begin
                    m_mode = 1; m_n = 0; m_rep_on = 0;
                end
            end else if (m_mode == 1) begin
                m_n++;
                if (m_n % P_DIV == 0) m_ns = 1;
                if (m_pend[1]) m_mode = 0;
            end
            m_strobe = m_ns;
            for (int b = 0; b < 2; b++) begin
                m_pend[b] = 1'b0;
                if (m_h1[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == P_DB) begin
                        m_lvl[b]  = m_h1[b];
                        m_run[b]  = 0;
                        m_pend[b] = m_h1[b];
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_h1 = m_h0;
            m_h0 = {mode_btn, step_btn};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; step_btn = 1'b0; mode_btn = 1'b0; halt_i = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        first = -1;
        @(negedge clk);
        reset = 1'b1; step_btn = 1'b1; mode_btn = 1'b0; halt_i = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({clk_en, run_mode_o, halted_o, heartbeat_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000", {clk_en, run_mode_o, halted_o, heartbeat_o});
        end
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (clk_en && first < 0) first = i;
        end
        n_checks++;
        if (first != 7) begin
            n_fail++;
            $display("FAIL reset_redebounce: first strobe at %0d expected 7", first);
        end
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_step_press();
        int first, pulses;
        first = -1; pulses = 0;
        do_reset();
        step_btn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            n_checks++;
            if (clk_en !== (m_strobe & ~halt_i)) begin
                n_fail++;
                $display("FAIL step_model cycle %0d: clk_en %b expected %b", i, clk_en, m_strobe & ~halt_i);
            end
            if (clk_en) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL step_pulses: got %0d expected 1", pulses); end
        n_checks++;
        if (first != 7) begin n_fail++; $display("FAIL step_latency: got %0d expected 7", first); end
        n_checks++;
        if (heartbeat_o !== 1'b1) begin n_fail++; $display("FAIL step_heartbeat: got %b expected 1", heartbeat_o); end
        n_checks++;
        if (run_mode_o !== 1'b0) begin n_fail++; $display("FAIL step_runmode: got %b expected 0", run_mode_o); end
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (clk_en) pulses++;
            step_btn = (i % 3 != 2);
        end
        step_btn = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", pulses); end
        n_checks++;
        if (heartbeat_o !== 1'b1) begin n_fail++; $display("FAIL glitch_heartbeat: got %b expected 1", heartbeat_o); end
    endtask

    task automatic test_run_mode();
        int entry, first, pulses, gap_bad, last, exit_at, after;
        entry = -1; first = -1; pulses = 0; gap_bad = 0; last = -1; exit_at = -1; after = 0;
        do_reset();
        mode_btn = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            n_checks++;
            if (clk_en !== (m_strobe & ~halt_i)) begin
                n_fail++;
                $display("FAIL run_model cycle %0d: clk_en %b expected %b", i, clk_en, m_strobe & ~halt_i);
            end
            if (i == 10) mode_btn = 1'b0;
            if (run_mode_o && entry < 0) entry = i;
            if (clk_en && entry >= 0 && i <= entry + 50) begin
                pulses++;
                if (first < 0) first = i - entry;
                if (last >= 0 && i - last != P_DIV) gap_bad++;
                last = i;
            end
        end
        n_checks++;
        if (entry != 7) begin n_fail++; $display("FAIL run_entry: got %0d expected 7", entry); end
        n_checks++;
        if (first != P_DIV) begin n_fail++; $display("FAIL run_first: got %0d expected %0d", first, P_DIV); end
        n_checks++;
        if (pulses != 10) begin n_fail++; $display("FAIL run_count: got %0d expected 10", pulses); end
        n_checks++;
        if (gap_bad != 0) begin n_fail++; $display("FAIL run_spacing: got %0d bad gaps expected 0", gap_bad); end
        mode_btn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 10) mode_btn = 1'b0;
            if (exit_at >= 0 && clk_en) after++;
            if (!run_mode_o && exit_at < 0) exit_at = i;
        end
        n_checks++;
        if (exit_at != 7) begin n_fail++; $display("FAIL run_exit: got %0d expected 7", exit_at); end
        n_checks++;
        if (after != 0) begin n_fail++; $display("FAIL run_stop: got %0d pulses expected 0", after); end
    endtask

    task automatic test_halt();
        int found, pulses;
        found = 0; pulses = 0;
        do_reset();
        mode_btn = 1'b1;
        repeat (10) @(negedge clk);
        mode_btn = 1'b0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (m_strobe) found = 1;
        end
        n_checks++;
        if (found != 1) begin n_fail++; $display("FAIL halt_strobe_due: got %0d expected 1", found); end
        halt_i = 1'b1;
        #1;
        n_checks++;
        if (clk_en !== 1'b0) begin n_fail++; $display("FAIL halt_mask: clk_en %b expected 0", clk_en); end
        @(posedge clk);
        #1;
        n_checks++;
        if ({halted_o, run_mode_o, clk_en} !== 3'b100) begin
            n_fail++;
            $display("FAIL halt_enter: halted/run/clk_en %b expected 100", {halted_o, run_mode_o, clk_en});
        end
        @(negedge clk);
        halt_i = 1'b0; mode_btn = 1'b1; step_btn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) begin mode_btn = 1'b0; step_btn = 1'b0; end
            if (clk_en) pulses++;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL halt_no_strobe: got %0d expected 0", pulses); end
        n_checks++;
        if ({halted_o, heartbeat_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL halt_sticky: halted/heartbeat %b expected 10", {halted_o, heartbeat_o});
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({halted_o, run_mode_o, clk_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL halt_reset: halted/run/clk_en %b expected 000", {halted_o, run_mode_o, clk_en});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_simultaneous();
        int t1, t2, pulses, rm1;
        t1 = -1; t2 = -1; pulses = 0; rm1 = -1;
        do_reset();
        step_btn = 1'b1; mode_btn = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (i == 10) begin step_btn = 1'b0; mode_btn = 1'b0; end
            if (clk_en) begin
                pulses++;
                if (t1 < 0) begin t1 = i; rm1 = run_mode_o; end
                else if (t2 < 0) t2 = i;
            end
        end
        n_checks++;
        if (t1 != 7) begin n_fail++; $display("FAIL simul_first: got %0d expected 7", t1); end
        n_checks++;
        if (rm1 != 1) begin n_fail++; $display("FAIL simul_runmode: got %0d expected 1", rm1); end
        n_checks++;
        if (t2 - t1 != P_DIV) begin n_fail++; $display("FAIL simul_gap: got %0d expected %0d", t2 - t1, P_DIV); end
        n_checks++;
        if (pulses != 4) begin n_fail++; $display("FAIL simul_count: got %0d expected 4", pulses); end
    endtask

    task automatic test_hold();
        int pulses, exp_n;
        int times [8];
        int expt;
        pulses = 0;
        exp_n = REP_ON ? 6 : 1;
        do_reset();
        step_btn = 1'b1;
        for (int i = 1; i <= 66; i++) begin
            @(negedge clk);
            if (clk_en) begin
                if (pulses < 8) times[pulses] = i - 7;
                pulses++;
            end
        end
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (pulses != exp_n) begin n_fail++; $display("FAIL hold_count: got %0d expected %0d", pulses, exp_n); end
        for (int k = 0; k < exp_n && k < pulses; k++) begin
            expt = (k == 0) ? 0 : P_RD + (k - 1) * P_RP;
            n_checks++;
            if (times[k] != expt) begin
                n_fail++;
                $display("FAIL hold_time[%0d]: got %0d expected %0d", k, times[k], expt);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] got, want;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            got  = {clk_en, run_mode_o, halted_o, heartbeat_o};
            want = {m_strobe & ~halt_i, m_mode == 1, m_mode == 2, m_hb};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random cycle %0d: clk_en/run/halted/hb %b expected %b", i, got, want);
            end
            if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 14) == 0) mode_btn = ~mode_btn;
            if (i > 350 && $urandom_range(0, 19) == 0) halt_i = 1'b1;
        end
        halt_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step_press();
        test_glitch();
        test_run_mode();
        test_halt();
        test_simultaneous();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
